// File: rtl/pwm_pkg.sv
// Shared types, defaults and step arithmetic for the pwm ramp sequencer.
// step_toward moves cur toward tgt by at most step (0 means jump all the way).
package pwm_pkg;

    localparam int W            = 16;
    localparam int RESET_PERIOD = 1000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        UPDATE,
        DONE
    } state_e;

    function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                                 input logic [W-1:0] tgt,
                                                 input logic [W-1:0] step);
        logic          up;
        logic [W:0]    diff;
        logic [W:0]    delta;
        logic [W:0]    nxt;
        up    = (tgt >= cur);
        diff  = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        delta = ((step == '0) || ({1'b0, step} >= diff)) ? diff : {1'b0, step};
        nxt   = up ? ({1'b0, cur} + delta) : ({1'b0, cur} - delta);
        return nxt[W-1:0];
    endfunction

endpackage

// File: rtl/pwm_edge_wait.sv
// Detects a rising edge on the pwm feedback and, while armed, fires on that
// edge or after EDGE_TIMEOUT cycles so a stalled channel cannot hang a ramp.
module pwm_edge_wait #(
    parameter int EDGE_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    input  logic arm,
    output logic fire
);

    localparam int CW = (EDGE_TIMEOUT > 1) ? $clog2(EDGE_TIMEOUT) : 1;

    logic          pwm_q;
    logic          pwm_d;
    logic          rise;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter only runs while armed; any exit (fire or disarm) clears it.
    always_comb begin
        pwm_d = pwm_in;
        rise  = pwm_in & ~pwm_q;
        fire  = arm & (rise | (cnt_q == CW'(EDGE_TIMEOUT - 1)));
        cnt_d = (arm && !fire) ? (cnt_q + CW'(1)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pwm_q <= pwm_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps one pwm channel's high time toward a target, rewriting HighTime and
// LowTime once per pwm period by at most the commanded step.
module pwm_ramp_ctrl #(
    parameter int W            = pwm_pkg::W,
    parameter int RESET_PERIOD = pwm_pkg::RESET_PERIOD,
    parameter int EDGE_TIMEOUT = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_target,
    input  logic [W-1:0] cfg_step,
    input  logic         abort,
    input  logic         pwm_in,
    output logic [W-1:0] high_time,
    output logic [W-1:0] low_time,
    output logic         high_write,
    output logic         low_write,
    output logic         busy,
    output logic         done
);

    import pwm_pkg::*;

    state_e        state_q;
    state_e        state_d;
    logic [W-1:0]  high_time_q;
    logic [W-1:0]  high_time_d;
    logic [W-1:0]  low_time_q;
    logic [W-1:0]  low_time_d;
    logic [W-1:0]  period_q;
    logic [W-1:0]  period_d;
    logic [W-1:0]  tgt_q;
    logic [W-1:0]  tgt_d;
    logic [W-1:0]  step_q;
    logic [W-1:0]  step_d;
    logic [W-1:0]  nxt;
    logic [W-1:0]  clamped;
    logic [W:0]    cur_sum;
    logic          arm;
    logic          fire;

    // abort disarms the waiter so it wins over a simultaneous rise or timeout.
    assign arm = (state_q == WAIT_EDGE) && !abort;

    pwm_edge_wait #(
        .EDGE_TIMEOUT(EDGE_TIMEOUT)
    ) u_edge_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .arm   (arm),
        .fire  (fire)
    );

    // New times are registered on the firing cycle so they appear together
    // with the strobes in UPDATE.
    always_comb begin
        state_d     = state_q;
        high_time_d = high_time_q;
        low_time_d  = low_time_q;
        period_d    = period_q;
        tgt_d       = tgt_q;
        step_d      = step_q;
        nxt         = step_toward(high_time_q, tgt_q, step_q);
        clamped     = (cfg_target > cfg_period) ? cfg_period : cfg_target;
        cur_sum     = {1'b0, high_time_q} + {1'b0, low_time_q};
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    period_d = cfg_period;
                    tgt_d    = clamped;
                    step_d   = cfg_step;
                    if ((clamped == high_time_q) && ({1'b0, cfg_period} == cur_sum))
                        state_d = DONE;
                    else
                        state_d = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (fire) begin
                    high_time_d = nxt;
                    low_time_d  = period_q - nxt;
                    state_d     = UPDATE;
                end
            end
            UPDATE: begin
                if (abort)
                    state_d = IDLE;
                else if (high_time_q == tgt_q)
                    state_d = DONE;
                else
                    state_d = WAIT_EDGE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            high_time_q <= '0;
            low_time_q  <= W'(RESET_PERIOD);
            period_q    <= '0;
            tgt_q       <= '0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            high_time_q <= high_time_d;
            low_time_q  <= low_time_d;
            period_q    <= period_d;
            tgt_q       <= tgt_d;
            step_q      <= step_d;
        end
    end

    assign high_time  = high_time_q;
    assign low_time   = low_time_q;
    assign high_write = (state_q == UPDATE);
    assign low_write  = (state_q == UPDATE);
    assign busy       = (state_q != IDLE);
    assign cfg_ready  = (state_q == IDLE);
    assign done       = (state_q == DONE);

endmodule
